// File: rtl/key_event_classifier.sv
// Classifies debounced key press/release pulses into SHORT, DOUBLE, LONG and
// REPEAT gestures and presents them through a one-entry valid/ready register.
module key_event_classifier #(
  parameter int FREQ      = 100,
  parameter int LONG_MS   = 1000,
  parameter int DCLICK_MS = 300,
  parameter int REPEAT_MS = 200,
  parameter int N         = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_press,
  input  logic       key_release,
  output logic       evt_valid,
  output logic [1:0] evt_code,
  input  logic       evt_ready,
  output logic       evt_drop,
  output logic       key_held
);

  localparam int LONG_C = LONG_MS * FREQ * 1000;
  localparam int DCLK_C = DCLICK_MS * FREQ * 1000;
  localparam int REP_C  = REPEAT_MS * FREQ * 1000;
  localparam bit REP_EN = (REPEAT_MS != 0);

  // Timeout thresholds: a timeout of X cycles fires when timer == X-1.
  localparam logic [N-1:0] LONG_T = N'(LONG_C - 1);
  localparam logic [N-1:0] DCLK_T = N'(DCLK_C - 1);
  localparam logic [N-1:0] REP_T  = REP_EN ? N'(REP_C - 1) : '0;

  localparam logic [1:0] EV_SHORT  = 2'd0;
  localparam logic [1:0] EV_DOUBLE = 2'd1;
  localparam logic [1:0] EV_LONG   = 2'd2;
  localparam logic [1:0] EV_REPEAT = 2'd3;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PRESS1 = 3'd1,
    WAIT2  = 3'd2,
    PRESS2 = 3'd3,
    HOLD   = 3'd4
  } state_t;

  state_t         state, next_state;
  logic [N-1:0]   timer;
  logic           press_v, rel_v;
  logic           emit, rep_fire, clr_timer, held_next;
  logic [1:0]     emit_code;

  // Simultaneous press and release cannot come from a sane debouncer; drop both.
  assign press_v = key_press & ~key_release;
  assign rel_v   = key_release & ~key_press;

  always_comb begin
    next_state = state;
    emit       = 1'b0;
    emit_code  = EV_SHORT;
    rep_fire   = 1'b0;
    case (state)
      IDLE: begin
        if (press_v) next_state = PRESS1;
      end
      PRESS1: begin
        if (rel_v) begin
          next_state = WAIT2;
        end else if (timer == LONG_T) begin
          next_state = HOLD;
          emit       = 1'b1;
          emit_code  = EV_LONG;
        end
      end
      WAIT2: begin
        if (press_v) begin
          next_state = PRESS2;
        end else if (timer == DCLK_T) begin
          next_state = IDLE;
          emit       = 1'b1;
          emit_code  = EV_SHORT;
        end
      end
      PRESS2: begin
        if (rel_v) begin
          next_state = IDLE;
          emit       = 1'b1;
          emit_code  = EV_DOUBLE;
        end else if (timer == LONG_T) begin
          next_state = HOLD;
          emit       = 1'b1;
          emit_code  = EV_LONG;
        end
      end
      HOLD: begin
        if (rel_v) begin
          next_state = IDLE;
        end else if (REP_EN && timer == REP_T) begin
          emit      = 1'b1;
          emit_code = EV_REPEAT;
          rep_fire  = 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
    clr_timer = (next_state != state) | rep_fire;
    held_next = (next_state == PRESS1) | (next_state == PRESS2) | (next_state == HOLD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      timer    <= '0;
      key_held <= 1'b0;
    end else begin
      state    <= next_state;
      timer    <= clr_timer ? '0 : timer + N'(1);
      key_held <= held_next;
    end
  end

  // Handshake: an event transfers on a cycle with evt_valid & evt_ready; while
  // evt_valid & !evt_ready the register holds and any new event is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      evt_valid <= 1'b0;
      evt_code  <= EV_SHORT;
      evt_drop  <= 1'b0;
    end else begin
      evt_drop <= emit & evt_valid & ~evt_ready;
      if (emit && (!evt_valid || evt_ready)) begin
        evt_valid <= 1'b1;
        evt_code  <= emit_code;
      end else if (evt_valid && evt_ready) begin
        evt_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_key_event_classifier.sv
// Directed bench for key_event_classifier with short timing constants
// (LONG=2000, DCLICK=1000, REPEAT=1000 cycles).
module tb_key_event_classifier;

  logic       clk;
  logic       rst;
  logic       key_press;
  logic       key_release;
  logic       evt_valid;
  logic [1:0] evt_code;
  logic       evt_ready;
  logic       evt_drop;
  logic       key_held;

  int tests_run;
  int tests_failed;
  int cyc;
  int drop_cnt;
  int obs_code_q[$];
  int obs_cyc_q[$];

  key_event_classifier #(
    .FREQ(1), .LONG_MS(2), .DCLICK_MS(1), .REPEAT_MS(1), .N(32)
  ) dut (
    .clk(clk), .rst(rst), .key_press(key_press), .key_release(key_release),
    .evt_valid(evt_valid), .evt_code(evt_code), .evt_ready(evt_ready),
    .evt_drop(evt_drop), .key_held(key_held)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Record accepted events and drop pulses away from the active edge.
  always @(negedge clk) begin
    if (!rst && evt_valid && evt_ready) begin
      obs_code_q.push_back(int'(evt_code));
      obs_cyc_q.push_back(cyc);
    end
    if (!rst && evt_drop) drop_cnt++;
  end

  // driver tasks
  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press_pulse(output int at);
    key_press = 1'b1;
    @(posedge clk);
    #1;
    at = cyc;
    key_press = 1'b0;
  endtask

  task automatic release_pulse(output int at);
    key_release = 1'b1;
    @(posedge clk);
    #1;
    at = cyc;
    key_release = 1'b0;
  endtask

  task automatic clear_log();
    obs_code_q.delete();
    obs_cyc_q.delete();
    drop_cnt = 0;
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    wait_cycles(3);
    tests_run++;
    if ({evt_valid, evt_code, evt_drop, key_held} !== 5'b0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got %b expected 00000", {evt_valid, evt_code, evt_drop, key_held});
    end
    rst = 1'b0;
    wait_cycles(2);
    tests_run++;
    if (evt_valid !== 1'b0 || key_held !== 1'b0) begin
      tests_failed++;
      $display("FAIL post_reset_idle: valid %b held %b expected 0 0", evt_valid, key_held);
    end
  endtask

  task automatic test_short(input string tag);
    int p, r;
    clear_log();
    press_pulse(p);
    tests_run++;
    if (key_held !== 1'b1) begin
      tests_failed++;
      $display("FAIL %s_held_rise: got %b expected 1", tag, key_held);
    end
    wait_cycles(99);
    release_pulse(r);
    tests_run++;
    if (key_held !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s_held_fall: got %b expected 0", tag, key_held);
    end
    wait_cycles(1100);
    check_int({tag, "_count"}, obs_code_q.size(), 1);
    if (obs_code_q.size() == 1) begin
      check_int({tag, "_code"}, obs_code_q[0], 0);
      check_int({tag, "_time"}, obs_cyc_q[0] - r, 1000);
    end
  endtask

  task automatic test_double();
    int p, r1, p2, r2;
    clear_log();
    press_pulse(p);
    wait_cycles(99);
    release_pulse(r1);
    wait_cycles(399);
    press_pulse(p2);
    check_int("double_gap", p2 - p, 500);
    wait_cycles(99);
    release_pulse(r2);
    wait_cycles(1200);
    check_int("double_count", obs_code_q.size(), 1);
    if (obs_code_q.size() == 1) begin
      check_int("double_code", obs_code_q[0], 1);
      check_int("double_time", obs_cyc_q[0] - r2, 0);
    end
  endtask

  task automatic test_long_repeat();
    int p, r;
    clear_log();
    press_pulse(p);
    wait_cycles(1000);
    check_int("long_held_mid", int'(key_held), 1);
    wait_cycles(3499);
    check_int("long_held_end", int'(key_held), 1);
    release_pulse(r);
    check_int("long_hold_len", r - p, 4500);
    check_int("long_held_after", int'(key_held), 0);
    wait_cycles(2000);
    check_int("long_count", obs_code_q.size(), 3);
    if (obs_code_q.size() == 3) begin
      check_int("long_code0", obs_code_q[0], 2);
      check_int("long_time0", obs_cyc_q[0] - p, 2000);
      check_int("long_code1", obs_code_q[1], 3);
      check_int("long_time1", obs_cyc_q[1] - p, 3000);
      check_int("long_code2", obs_code_q[2], 3);
      check_int("long_time2", obs_cyc_q[2] - p, 4000);
    end
  endtask

  task automatic test_backpressure();
    int p, r;
    clear_log();
    evt_ready = 1'b0;
    press_pulse(p);
    wait_cycles(2500);
    check_int("bp_valid_mid", int'(evt_valid), 1);
    check_int("bp_code_mid", int'(evt_code), 2);
    wait_cycles(1999);
    release_pulse(r);
    wait_cycles(500);
    check_int("bp_drops", drop_cnt, 2);
    check_int("bp_valid_end", int'(evt_valid), 1);
    check_int("bp_code_end", int'(evt_code), 2);
    check_int("bp_none_accepted", obs_code_q.size(), 0);
    evt_ready = 1'b1;
    wait_cycles(1);
    check_int("bp_accept_count", obs_code_q.size(), 1);
    if (obs_code_q.size() == 1) check_int("bp_accept_code", obs_code_q[0], 2);
    check_int("bp_valid_fall", int'(evt_valid), 0);
    wait_cycles(10);
    check_int("bp_drop_quiet", drop_cnt, 2);
  endtask

  task automatic test_edge_wins();
    int p, r;
    clear_log();
    press_pulse(p);
    wait_cycles(1999);
    release_pulse(r);
    check_int("race_release_at", r - p, 2000);
    check_int("race_held", int'(key_held), 0);
    wait_cycles(1100);
    check_int("race_count", obs_code_q.size(), 1);
    if (obs_code_q.size() == 1) begin
      check_int("race_code", obs_code_q[0], 0);
      check_int("race_time", obs_cyc_q[0] - r, 1000);
    end
  endtask

  task automatic test_mid_reset();
    int p;
    clear_log();
    press_pulse(p);
    wait_cycles(1499);
    rst = 1'b1;
    wait_cycles(1);
    rst = 1'b0;
    tests_run++;
    if ({evt_valid, evt_code, evt_drop, key_held} !== 5'b0) begin
      tests_failed++;
      $display("FAIL midrst_outputs: got %b expected 00000", {evt_valid, evt_code, evt_drop, key_held});
    end
    wait_cycles(2500);
    check_int("midrst_no_event", obs_code_q.size(), 0);
    check_int("midrst_held", int'(key_held), 0);
    test_short("midrst_short");
  endtask

  task automatic test_illegal_both();
    clear_log();
    key_press   = 1'b1;
    key_release = 1'b1;
    wait_cycles(1);
    key_press   = 1'b0;
    key_release = 1'b0;
    wait_cycles(1);
    check_int("both_held", int'(key_held), 0);
    wait_cycles(2500);
    check_int("both_no_event", obs_code_q.size(), 0);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    cyc          = 0;
    drop_cnt     = 0;
    rst          = 1'b1;
    key_press    = 1'b0;
    key_release  = 1'b0;
    evt_ready    = 1'b1;
    wait_cycles(1);
    test_reset();
    test_short("short");
    test_double();
    test_long_repeat();
    test_backpressure();
    test_edge_wins();
    test_mid_reset();
    test_illegal_both();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
